// File: rtl/smi_pkg.sv
// Shared encodings for the SMI receive streamer: modes, tag width, fetch states, byte order.
package smi_pkg;

    localparam logic MODE_SINGLE    = 1'b0;
    localparam logic MODE_RR        = 1'b1;
    localparam int   TAG_W          = 3;
    localparam bit   BYTE_MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEL,
        ST_WAIT,
        ST_LOAD
    } fetch_state_t;

endpackage

// File: rtl/smi_strobe_sync.sv
// SMI read-strobe synchroniser with end-of-strobe (rising edge) pulse.
// Latency: pulse 3 core cycles after the pin rises.
// Backpressure: none; one pulse per strobe.
module smi_strobe_sync (
    input  logic i_clk,
    input  logic i_rst_b,
    input  logic i_strobe_n,
    output logic o_adv
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_adv;

    // Idle level of the strobe is high, so the chain resets high to avoid a false edge.
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            r_adv  <= 1'b0;
        end else begin
            r_meta <= i_strobe_n;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_adv  <= r_sync & ~r_prev;
        end
    end

    assign o_adv = r_adv;

endmodule

// File: rtl/smi_rx_stream_mux.sv
// Streams 32-bit FIFO words from N channels onto the 8-bit SMI bus, one byte per read strobe.
// Latency: first byte 4 cycles after enable; byte advances 4 cycles after strobe release.
// Backpressure: one word prefetched; fetch FSM stalls in LOAD while prefetch is occupied.
module smi_rx_stream_mux
    import smi_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int WORD_W = 32,
    parameter  int CNT_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst_b,
    input  logic                     i_enable,
    input  logic                     i_mode,
    input  logic [CH_W-1:0]          i_ch_sel,
    input  logic [NUM_CH-1:0]        i_ch_mask,
    output logic [NUM_CH-1:0]        o_fifo_pull,
    input  logic [NUM_CH*WORD_W-1:0] i_fifo_data,
    input  logic [NUM_CH-1:0]        i_fifo_empty,
    input  logic                     i_smi_soe_se,
    output logic [7:0]               o_smi_data,
    output logic                     o_smi_read_req,
    output logic [CNT_W-1:0]         o_underrun_cnt,
    output logic [CH_W-1:0]          o_active_ch
);

    localparam int NB   = WORD_W / 8;
    localparam int BC_W = $clog2(NB + 1);

    typedef struct packed {
        logic              vld;
        logic [CH_W-1:0]   ch;
        logic [WORD_W-1:0] dat;
    } pf_t;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [CH_W-1:0]   r_rr_last;
    logic [CH_W-1:0]   w_rr_nxt;
    logic [CH_W-1:0]   w_rr_cand;
    logic [CH_W-1:0]   w_sel_ch;
    logic              w_sel_ok;
    logic              w_issue;
    logic [CH_W-1:0]   r_req_ch;
    logic              r_req_tag;
    logic [WORD_W-1:0] w_fifo_word;
    pf_t               r_pf;
    logic              w_pf_free;
    logic [WORD_W-1:0] r_sr;
    logic [BC_W-1:0]   r_sr_cnt;
    logic [CH_W-1:0]   r_sr_ch;
    logic              w_byte_vld;
    logic              w_sr_load;
    logic [7:0]        w_byte;
    logic [CNT_W-1:0]  r_unr;
    logic              w_adv;

    smi_strobe_sync u_strobe (
        .i_clk      (i_sys_clk),
        .i_rst_b    (i_rst_b),
        .i_strobe_n (i_smi_soe_se),
        .o_adv      (w_adv)
    );

    // Next set mask bit strictly after 'last', wrapping; returns 'last' for an empty mask.
    function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0]   last,
                                                input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] res;
        logic            found;
        int              idx;
        res   = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(last) + i) % NUM_CH;
            if (!found && mask[idx]) begin
                res   = CH_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_rr_cand = rr_next(r_rr_last, i_ch_mask);
    assign w_sel_ch  = (i_mode == MODE_SINGLE) ? i_ch_sel : w_rr_cand;
    assign w_sel_ok  = (i_mode == MODE_SINGLE) ? 1'b1 : |i_ch_mask;

    assign w_byte_vld = (r_sr_cnt != '0);
    assign w_sr_load  = r_pf.vld && (!w_byte_vld || (w_adv && r_sr_cnt == BC_W'(1)));
    assign w_pf_free  = !r_pf.vld || w_sr_load;

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_state   <= ST_IDLE;
            r_rr_last <= CH_W'(NUM_CH - 1);
            r_req_ch  <= '0;
            r_req_tag <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_last <= w_rr_nxt;
            if (w_issue) begin
                r_req_ch  <= w_sel_ch;
                r_req_tag <= (i_mode == MODE_RR);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_last;
        w_issue     = 1'b0;
        o_fifo_pull = '0;
        if (!i_enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_SEL;
                ST_SEL: begin
                    if (w_sel_ok) begin
                        // An empty candidate still advances the pointer so the next cycle tries the next channel.
                        if (i_mode == MODE_RR)
                            w_rr_nxt = w_sel_ch;
                        if (!i_fifo_empty[w_sel_ch]) begin
                            o_fifo_pull[w_sel_ch] = 1'b1;
                            w_issue               = 1'b1;
                            w_state_nxt           = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: w_state_nxt = ST_LOAD;
                ST_LOAD: begin
                    if (w_pf_free)
                        w_state_nxt = ST_SEL;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // In-band channel tag overwrites the unused top bits of the first byte sent.
    always_comb begin
        w_fifo_word = i_fifo_data[r_req_ch*WORD_W +: WORD_W];
        if (r_req_tag) begin
            if (BYTE_MSB_FIRST)
                w_fifo_word[WORD_W-1 -: TAG_W] = TAG_W'(r_req_ch);
            else
                w_fifo_word[7 -: TAG_W] = TAG_W'(r_req_ch);
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_pf <= '0;
        end else if (!i_enable) begin
            r_pf <= '0;
        end else if (r_state == ST_WAIT) begin
            r_pf.vld <= 1'b1;
            r_pf.ch  <= r_req_ch;
            r_pf.dat <= w_fifo_word;
        end else if (w_sr_load) begin
            r_pf.vld <= 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_sr     <= '0;
            r_sr_cnt <= '0;
            r_sr_ch  <= '0;
        end else if (!i_enable) begin
            r_sr     <= '0;
            r_sr_cnt <= '0;
        end else if (w_sr_load) begin
            r_sr     <= r_pf.dat;
            r_sr_cnt <= BC_W'(NB);
            r_sr_ch  <= r_pf.ch;
        end else if (w_adv && w_byte_vld) begin
            r_sr     <= BYTE_MSB_FIRST ? (r_sr << 8) : (r_sr >> 8);
            r_sr_cnt <= r_sr_cnt - BC_W'(1);
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b)
            r_unr <= '0;
        else if (w_adv && !w_byte_vld && (r_unr != {CNT_W{1'b1}}))
            r_unr <= r_unr + CNT_W'(1);
    end

    assign w_byte         = BYTE_MSB_FIRST ? r_sr[WORD_W-1 -: 8] : r_sr[7:0];
    assign o_smi_data     = w_byte_vld ? w_byte : 8'h00;
    assign o_smi_read_req = w_byte_vld;
    assign o_underrun_cnt = r_unr;
    assign o_active_ch    = r_sr_ch;

endmodule

// File: tb/tb_smi_rx_stream_mux.sv
// Directed bench for smi_rx_stream_mux: two modelled channel FIFOs, strobes on the SMI pin.
module tb_smi_rx_stream_mux;

    localparam int NUM_CH = 2;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 8;

    localparam logic [7:0] EXP2 [8]  = '{8'h0A, 8'h00, 8'h00, 8'h01, 8'h2B, 8'h00, 8'h00, 8'h02};
    localparam logic [7:0] EXP3 [12] = '{8'h21, 8'h11, 8'h22, 8'h33, 8'h24, 8'h44,
                                         8'h55, 8'h66, 8'h27, 8'h77, 8'h88, 8'h99};

    logic        clk      = 1'b0;
    logic        rst_b    = 1'b0;
    logic        enable   = 1'b0;
    logic        mode     = 1'b0;
    logic [0:0]  ch_sel   = 1'b0;
    logic [1:0]  ch_mask  = 2'b00;
    logic        soe      = 1'b1;
    logic [1:0]  fifo_pull;
    logic [63:0] fifo_data;
    logic [1:0]  fifo_empty;
    logic [7:0]  smi_data;
    logic        read_req;
    logic [7:0]  unr;
    logic [0:0]  active_ch;

    logic [31:0] mem [2][64];
    int          wr [2]     = '{0, 0};
    int          rd [2]     = '{0, 0};
    int          npull [2]  = '{0, 0};
    logic [31:0] fdata [2]  = '{32'h0, 32'h0};
    int          bad_pull   = 0;
    int          mon_drop   = 0;
    logic        mon_en     = 1'b0;
    int          n_assert   = 0;
    int          n_fail     = 0;

    always #5 clk = ~clk;

    smi_rx_stream_mux #(
        .NUM_CH (NUM_CH),
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .i_sys_clk      (clk),
        .i_rst_b        (rst_b),
        .i_enable       (enable),
        .i_mode         (mode),
        .i_ch_sel       (ch_sel),
        .i_ch_mask      (ch_mask),
        .o_fifo_pull    (fifo_pull),
        .i_fifo_data    (fifo_data),
        .i_fifo_empty   (fifo_empty),
        .i_smi_soe_se   (soe),
        .o_smi_data     (smi_data),
        .o_smi_read_req (read_req),
        .o_underrun_cnt (unr),
        .o_active_ch    (active_ch)
    );

    // Channel FIFO models: first-word-fall-through-free, data valid the cycle after a pull.
    assign fifo_data = {fdata[1], fdata[0]};
    always_comb begin
        for (int k = 0; k < 2; k++)
            fifo_empty[k] = (rd[k] == wr[k]);
    end

    always @(posedge clk) begin
        bad_pull <= bad_pull + (($countones(fifo_pull) > 1) ? 1 : 0)
                             + (((fifo_pull & fifo_empty) != 2'b00) ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
            if (fifo_pull[k]) begin
                npull[k] <= npull[k] + 1;
                if (rd[k] != wr[k]) begin
                    fdata[k] <= mem[k][rd[k]];
                    rd[k]    <= rd[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && !read_req)
            mon_drop <= mon_drop + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] w);
        mem[k][wr[k]] = w;
        wr[k]         = wr[k] + 1;
    endtask

    task automatic strobe();
        @(negedge clk) soe = 1'b0;
        @(negedge clk) soe = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Samples the presented byte while the strobe is low, then releases it.
    task automatic strobe_chk(input string tag, input logic [7:0] exp);
        @(negedge clk) soe = 1'b0;
        @(negedge clk);
        chk(tag, {24'h0, smi_data}, {24'h0, exp});
        soe = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (read_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'h0, read_req}, 32'h1);
    endtask

    task automatic wait_pull0(input string tag);
        int n = 0;
        while (fifo_pull[0] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'h0, fifo_pull[0]}, 32'h1);
    endtask

    task automatic flush();
        @(negedge clk) enable = 1'b0;
        repeat (3) @(negedge clk);
        wr[0] = rd[0];
        wr[1] = rd[1];
    endtask

    initial begin
        int p0;
        int p1;
        int u0;
        int d0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pull",   {30'h0, fifo_pull}, 32'h0);
        chk("rst_data",   {24'h0, smi_data},  32'h0);
        chk("rst_req",    {31'h0, read_req},  32'h0);
        chk("rst_unr",    {24'h0, unr},       32'h0);
        chk("rst_active", {31'h0, active_ch}, 32'h0);
        rst_b = 1'b1;

        // Mode 0, channel 1; ch0 holds a word that must not be touched
        push(1, 32'h11223344);
        push(0, 32'hDEADBEEF);
        mode   = 1'b0;
        ch_sel = 1'b1;
        p0 = npull[0];
        p1 = npull[1];
        @(negedge clk) enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_req_lat3", {31'h0, read_req}, 32'h0);
        @(negedge clk);
        chk("t1_req_lat4", {31'h0, read_req}, 32'h1);
        chk("t1_active", {31'h0, active_ch}, 32'h1);
        @(negedge clk) soe = 1'b0;
        @(negedge clk);
        chk("t1_b0", {24'h0, smi_data}, 32'h11);
        soe = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_strobe_lat_hold", {24'h0, smi_data}, 32'h11);
        @(negedge clk);
        chk("t1_strobe_lat_upd", {24'h0, smi_data}, 32'h22);
        strobe_chk("t1_b1", 8'h22);
        strobe_chk("t1_b2", 8'h33);
        strobe_chk("t1_b3", 8'h44);
        strobe_chk("t1_b4_underrun", 8'h00);
        repeat (2) @(negedge clk);
        chk("t1_unr",     {24'h0, unr},      32'h1);
        chk("t1_req_low", {31'h0, read_req}, 32'h0);
        chk("t1_pull_ch0", npull[0] - p0, 32'h0);
        chk("t1_pull_ch1", npull[1] - p1, 32'h1);

        // Mode 1 interleave with channel tag
        flush();
        mode    = 1'b1;
        ch_mask = 2'b11;
        push(0, 32'h0A000001);
        push(1, 32'h0B000002);
        @(negedge clk) enable = 1'b1;
        wait_req("t2_req");
        chk("t2_active0", {31'h0, active_ch}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            strobe_chk($sformatf("t2_b%0d", i), EXP2[i]);
            if (i == 4)
                chk("t2_active1", {31'h0, active_ch}, 32'h1);
        end
        repeat (3) @(negedge clk);
        chk("t2_unr", {24'h0, unr}, 32'h1);

        // Mode 1 with ch0 permanently empty
        flush();
        push(1, 32'h01112233);
        push(1, 32'h04445566);
        push(1, 32'h07778899);
        p0 = npull[0];
        p1 = npull[1];
        @(negedge clk) enable = 1'b1;
        wait_req("t3_req");
        for (int i = 0; i < 12; i++)
            strobe_chk($sformatf("t3_b%0d", i), EXP3[i]);
        repeat (3) @(negedge clk);
        chk("t3_pull_ch0", npull[0] - p0, 32'h0);
        chk("t3_pull_ch1", npull[1] - p1, 32'h3);
        chk("t3_bad_pull", bad_pull, 32'h0);

        // Back-to-back strobes every 4 cycles on a full FIFO
        flush();
        mode   = 1'b0;
        ch_sel = 1'b0;
        push(0, 32'h00010203);
        push(0, 32'h04050607);
        push(0, 32'h08090A0B);
        push(0, 32'h0C0D0E0F);
        @(negedge clk) enable = 1'b1;
        wait_req("t4_req");
        u0 = int'(unr);
        d0 = mon_drop;
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++)
            strobe_chk($sformatf("t4_b%0d", i), 8'(i));
        mon_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_req_gaps", mon_drop - d0, 32'h0);
        chk("t4_no_underrun", int'(unr) - u0, 32'h0);

        // Enable dropped the cycle after a pull
        flush();
        push(0, 32'hA1A2A3A4);
        push(0, 32'h99887766);
        push(0, 32'h5A5B5C5D);
        p0 = npull[0];
        @(negedge clk) enable = 1'b1;
        wait_req("t5_req");
        strobe_chk("t5_b0", 8'hA1);
        strobe_chk("t5_b1", 8'hA2);
        strobe_chk("t5_b2", 8'hA3);
        strobe_chk("t5_b3", 8'hA4);
        wait_pull0("t5_pull_w3");
        @(negedge clk);
        chk("t5_w2_shifting", {24'h0, smi_data}, 32'h99);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_req_drop", {31'h0, read_req}, 32'h0);
        chk("t5_pulls", npull[0] - p0, 32'h3);
        push(0, 32'h3C4D5E6F);
        @(negedge clk) enable = 1'b1;
        wait_req("t5_restart_req");
        chk("t5_restart_byte", {24'h0, smi_data}, 32'h3C);
        chk("t5_restart_pulls", npull[0] - p0, 32'h4);

        // Asynchronous reset mid-word, then counter saturation
        flush();
        ch_sel = 1'b1;
        push(1, 32'h12345678);
        @(negedge clk) enable = 1'b1;
        wait_req("t6_req");
        strobe_chk("t6_b0", 8'h12);
        repeat (2) @(negedge clk);
        chk("t6_mid_byte", {24'h0, smi_data}, 32'h34);
        chk("t6_mid_active", {31'h0, active_ch}, 32'h1);
        #2 rst_b = 1'b0;
        #1;
        chk("t6_arst_pull",   {30'h0, fifo_pull}, 32'h0);
        chk("t6_arst_data",   {24'h0, smi_data},  32'h0);
        chk("t6_arst_req",    {31'h0, read_req},  32'h0);
        chk("t6_arst_unr",    {24'h0, unr},       32'h0);
        chk("t6_arst_active", {31'h0, active_ch}, 32'h0);
        enable = 1'b0;
        @(negedge clk) rst_b = 1'b1;
        repeat (254) strobe();
        repeat (2) @(negedge clk);
        chk("t6_unr_254", {24'h0, unr}, 32'd254);
        strobe();
        repeat (2) @(negedge clk);
        chk("t6_unr_255", {24'h0, unr}, 32'd255);
        repeat (2745) strobe();
        repeat (2) @(negedge clk);
        chk("t6_unr_sat", {24'h0, unr}, 32'd255);
        chk("t6_bad_pull", bad_pull, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
